// File: rtl/alu_muldiv.sv
// alu_muldiv: registered execute unit with signed/unsigned compare, shifts, and
// an iterative multiply/divide engine feeding HI/LO. busy stalls the pipeline
// while a mul/div is in flight.
// Optional feature macro: ALU_OVERFLOW_EN enables trapping ADDT (0x14) and
// SUBT (0x15); without it those codes are undefined and ovf is tied low.
module alu_muldiv #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] opr_a,
  input  logic [XLEN-1:0] opr_b,
  input  logic            flush,
  output logic            busy,
  output logic            out_valid,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            md_done,
  output logic            div_by_zero,
  output logic            ovf
);

  localparam logic [4:0] OP_ADD   = 5'h01, OP_SUB   = 5'h02, OP_AND  = 5'h03,
                         OP_OR    = 5'h04, OP_XOR   = 5'h05, OP_NOR  = 5'h06,
                         OP_SLTU  = 5'h07, OP_SLL   = 5'h08, OP_SRL  = 5'h09,
                         OP_SRA   = 5'h0A, OP_SLT   = 5'h0B, OP_MULT = 5'h0C,
                         OP_MULTU = 5'h0D, OP_DIV   = 5'h0E, OP_DIVU = 5'h0F,
                         OP_MFHI  = 5'h10, OP_MFLO  = 5'h11, OP_MTHI = 5'h12,
                         OP_MTLO  = 5'h13;
`ifdef ALU_OVERFLOW_EN
  localparam logic [4:0] OP_ADDT  = 5'h14, OP_SUBT  = 5'h15;
`endif

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  // context captured when a mul/div starts; FIX uses it to sign-correct
  typedef struct packed {
    logic is_div;
    logic dz;
    logic neg_q;   // negate product / quotient
    logic neg_r;   // negate remainder (dividend sign)
  } md_ctx_t;

  state_t             state, state_nxt;
  md_ctx_t            ctx;
  logic               accept, start_mul, start_div, div_zero;
  logic               last_iter, md_commit;
  logic [SHAMT_W-1:0] cnt;
  logic [XLEN:0]      md_hi;        // product high half / partial remainder
  logic [XLEN-1:0]    md_lo;        // multiplier / quotient (raw dividend if dz)
  logic [XLEN-1:0]    md_b;         // multiplicand / divisor magnitude

  // flush kills anything presented alongside it; nothing is taken while busy
  assign accept    = in_valid && !flush && (state == S_IDLE);
  assign start_mul = accept && ((op == OP_MULT) || (op == OP_MULTU));
  assign start_div = accept && ((op == OP_DIV) || (op == OP_DIVU));
  assign div_zero  = (opr_b == '0);
  assign last_iter = (cnt == SHAMT_W'(XLEN - 1));

  // signed ops run the engine on magnitudes; signs reapplied in FIX
  logic            signed_op, sa, sb;
  logic [XLEN-1:0] mag_a, mag_b;
  assign signed_op = (op == OP_MULT) || (op == OP_DIV);
  assign sa        = signed_op && opr_a[XLEN-1];
  assign sb        = signed_op && opr_b[XLEN-1];
  assign mag_a     = sa ? (~opr_a + 1'b1) : opr_a;
  assign mag_b     = sb ? (~opr_b + 1'b1) : opr_b;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state: XLEN iterations then one FIX cycle; divide-by-zero skips to FIX
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start_mul)      state_nxt = S_MUL;
        else if (start_div) state_nxt = div_zero ? S_FIX : S_DIV;
      end
      S_MUL, S_DIV: begin
        if (flush)          state_nxt = S_IDLE;
        else if (last_iter) state_nxt = S_FIX;
      end
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: stall while engine owns the unit; commit unless flushed in FIX
  always_comb begin
    busy      = (state != S_IDLE);
    md_commit = (state == S_FIX) && !flush;
  end

  // one shift-add multiply step and one restoring divide step
  logic [XLEN:0] mul_sum, div_sh, div_diff;
  logic          div_ge;
  assign mul_sum  = md_hi + (md_lo[0] ? {1'b0, md_b} : '0);
  assign div_sh   = {md_hi[XLEN-1:0], md_lo[XLEN-1]};
  assign div_ge   = (div_sh >= {1'b0, md_b});
  assign div_diff = div_sh - {1'b0, md_b};

  // engine datapath: load on start, iterate in MUL/DIV
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      md_hi <= '0;
      md_lo <= '0;
      md_b  <= '0;
      ctx   <= '0;
    end else if (start_mul || start_div) begin
      cnt   <= '0;
      md_hi <= '0;
      md_lo <= (start_div && div_zero) ? opr_a : mag_a;
      md_b  <= mag_b;
      ctx   <= '{is_div: start_div, dz: start_div && div_zero,
                 neg_q: sa ^ sb, neg_r: sa};
    end else if (state == S_MUL) begin
      cnt   <= cnt + 1'b1;
      md_hi <= {1'b0, mul_sum[XLEN:1]};
      md_lo <= {mul_sum[0], md_lo[XLEN-1:1]};
    end else if (state == S_DIV) begin
      cnt   <= cnt + 1'b1;
      md_hi <= div_ge ? div_diff : div_sh;
      md_lo <= {md_lo[XLEN-2:0], div_ge};
    end
  end

  // sign correction; MIN/-1 falls out naturally as lo=MIN, hi=0
  logic [2*XLEN-1:0] prod_mag, prod;
  logic [XLEN-1:0]   quot, rem;
  assign prod_mag = {md_hi[XLEN-1:0], md_lo};
  assign prod     = ctx.neg_q ? (~prod_mag + 1'b1) : prod_mag;
  assign quot     = ctx.neg_q ? (~md_lo + 1'b1) : md_lo;
  assign rem      = ctx.neg_r ? (~md_hi[XLEN-1:0] + 1'b1) : md_hi[XLEN-1:0];

  // HI/LO: MTHI/MTLO at accept, engine result at FIX exit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
    end else begin
      if (accept && (op == OP_MTHI)) hi <= opr_a;
      if (accept && (op == OP_MTLO)) lo <= opr_a;
      if (md_commit) begin
        if (ctx.dz) begin
          hi <= md_lo;
          lo <= '1;
        end else if (ctx.is_div) begin
          hi <= rem;
          lo <= quot;
        end else begin
          {hi, lo} <= prod;
        end
      end
    end
  end

  // completion pulses, one cycle after FIX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_done     <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      md_done     <= md_commit;
      div_by_zero <= md_commit && ctx.dz;
    end
  end

  // single-cycle result; single=0 marks ops that produce no out_valid
  logic               single;
  logic [XLEN-1:0]    alu_res;
  logic [SHAMT_W-1:0] shamt;
`ifdef ALU_OVERFLOW_EN
  logic               ovf_hit;
`endif
  assign shamt = opr_a[SHAMT_W-1:0];

  // ALU function select
  always_comb begin
    single  = 1'b1;
    alu_res = '0;
`ifdef ALU_OVERFLOW_EN
    ovf_hit = 1'b0;
`endif
    case (op)
      OP_ADD:  alu_res = opr_a + opr_b;
      OP_SUB:  alu_res = opr_a - opr_b;
      OP_AND:  alu_res = opr_a & opr_b;
      OP_OR:   alu_res = opr_a | opr_b;
      OP_XOR:  alu_res = opr_a ^ opr_b;
      OP_NOR:  alu_res = ~(opr_a | opr_b);
      OP_SLTU: alu_res = XLEN'(opr_a < opr_b);
      OP_SLT:  alu_res = XLEN'($signed(opr_a) < $signed(opr_b));
      OP_SLL:  alu_res = opr_b << shamt;
      OP_SRL:  alu_res = opr_b >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(opr_b) >>> shamt);
      OP_MFHI: alu_res = hi;
      OP_MFLO: alu_res = lo;
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO: single = 1'b0;
`ifdef ALU_OVERFLOW_EN
      OP_ADDT: begin
        alu_res = opr_a + opr_b;
        ovf_hit = (opr_a[XLEN-1] == opr_b[XLEN-1]) && (alu_res[XLEN-1] != opr_a[XLEN-1]);
        single  = !ovf_hit;
      end
      OP_SUBT: begin
        alu_res = opr_a - opr_b;
        ovf_hit = (opr_a[XLEN-1] != opr_b[XLEN-1]) && (alu_res[XLEN-1] != opr_a[XLEN-1]);
        single  = !ovf_hit;
      end
`endif
      default: alu_res = '0;
    endcase
  end

  // registered result; result holds when nothing single-cycle completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      zero      <= 1'b0;
      result    <= '0;
    end else begin
      out_valid <= accept && single;
      zero      <= accept && single && (alu_res == '0);
      if (accept && single) result <= alu_res;
    end
  end

`ifdef ALU_OVERFLOW_EN
  // trap pulse for ADDT/SUBT signed overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf <= 1'b0;
    else        ovf <= accept && ovf_hit;
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv (XLEN=32): single-cycle vector table plus
// hand-written mul/div, flush and async-reset sequences.
module tb_alu_muldiv;
  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, flush = 1'b0;
  logic [4:0]  op = '0;
  logic [31:0] opr_a = '0, opr_b = '0;
  logic        busy, out_valid, zero, md_done, div_by_zero, ovf;
  logic [31:0] result, hi, lo;
  int          n_chk = 0, n_fail = 0;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a, b, res;
    logic        z;
  } vec_t;
  vec_t vecs[16];

  alu_muldiv #(.XLEN(32), .SHAMT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .op(op), .opr_a(opr_a),
    .opr_b(opr_b), .flush(flush), .busy(busy), .out_valid(out_valid),
    .result(result), .zero(zero), .hi(hi), .lo(lo), .md_done(md_done),
    .div_by_zero(div_by_zero), .ovf(ovf));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // drive at negedge, accepted at the next posedge, return 1ns after it
  task automatic issue(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    in_valid = 1'b1; op = o; opr_a = a; opr_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // follow a mul/div until md_done or busy drops; optional injection at busy cycle inj_at
  task automatic run_md(input int inj_at, input bit inj_flush,
                        output int bc, output bit done, output bit dz, output bit stray);
    bc = 0; done = 0; dz = 0; stray = 0;
    for (int k = 0; k < 100; k++) begin
      if (md_done) begin
        done = 1; dz = div_by_zero;
        break;
      end
      if (out_valid) stray = 1;
      if (!busy) break;
      bc++;
      if (bc == inj_at) begin
        @(negedge clk);
        if (inj_flush) flush = 1'b1;
        else begin in_valid = 1'b1; op = 5'h13; opr_a = 32'h1234; end
      end
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
    end
    if (!done && !inj_flush) begin
      n_chk++; n_fail++;
      $display("FAIL md_wait: got no md_done expected md_done within bound");
    end
  endtask

  int bc; bit done, dz, stray, seen;

  initial begin
    vecs[0]  = '{5'h01, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0};
    vecs[1]  = '{5'h02, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1};
    vecs[2]  = '{5'h03, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0};
    vecs[3]  = '{5'h04, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 1'b0};
    vecs[4]  = '{5'h05, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1'b0};
    vecs[5]  = '{5'h06, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0};
    vecs[6]  = '{5'h07, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1};
    vecs[7]  = '{5'h0B, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0};
    vecs[8]  = '{5'h08, 32'h00000004, 32'h00000001, 32'h00000010, 1'b0};
    vecs[9]  = '{5'h09, 32'h00000004, 32'h80000000, 32'h08000000, 1'b0};
    vecs[10] = '{5'h0A, 32'h00000004, 32'h80000000, 32'hF8000000, 1'b0};
    vecs[11] = '{5'h0A, 32'h00000024, 32'h80000000, 32'hF8000000, 1'b0};
    vecs[12] = '{5'h02, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0};
    vecs[13] = '{5'h01, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1};
    vecs[14] = '{5'h00, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1};
    vecs[15] = '{5'h1F, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", result, 32'h0);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_flags", {26'h0, busy, out_valid, zero, md_done, div_by_zero, ovf}, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    // back-to-back single-cycle vectors
    for (int i = 0; i < 16; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'h1);
      chk($sformatf("vec%0d_result", i), result, vecs[i].res);
      chk($sformatf("vec%0d_zero", i), 32'(zero), 32'(vecs[i].z));
      chk($sformatf("vec%0d_ovf", i), 32'(ovf), 32'h0);
    end

    // MTHI/MTLO produce no out_valid, MFHI/MFLO read them back
    issue(5'h12, 32'h12345678, 32'h0);
    chk("mthi_novalid", 32'(out_valid), 32'h0);
    issue(5'h13, 32'h9ABCDEF0, 32'h0);
    issue(5'h10, 32'h0, 32'h0);
    chk("mfhi", result, 32'h12345678);
    issue(5'h11, 32'h0, 32'h0);
    chk("mflo", result, 32'h9ABCDEF0);

    // MULT -1 x 7, MFHI in the md_done cycle
    issue(5'h0C, 32'hFFFFFFFF, 32'h7);
    run_md(0, 0, bc, done, dz, stray);
    chk("mult_busy_cycles", 32'(bc), 32'd33);
    chk("mult_done", 32'(done), 32'h1);
    chk("mult_stray_valid", 32'(stray), 32'h0);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFF9);
    issue(5'h10, 32'h0, 32'h0);
    chk("mfhi_at_done", result, 32'hFFFFFFFF);
    chk("md_done_pulse", 32'(md_done), 32'h0);
    issue(5'h11, 32'h0, 32'h0);
    chk("mflo_after_mult", result, 32'hFFFFFFF9);

    issue(5'h0D, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_md(0, 0, bc, done, dz, stray);
    chk("multu_hi", hi, 32'hFFFFFFFE);
    chk("multu_lo", lo, 32'h00000001);

    issue(5'h0C, 32'hFFFFFFFD, 32'h5);
    run_md(0, 0, bc, done, dz, stray);
    chk("mult_neg_hi", hi, 32'hFFFFFFFF);
    chk("mult_neg_lo", lo, 32'hFFFFFFF1);

    // DIV -7/2 with an MTLO presented while busy (must be ignored)
    issue(5'h0E, 32'hFFFFFFF9, 32'h2);
    run_md(3, 0, bc, done, dz, stray);
    chk("div_busy_cycles", 32'(bc), 32'd33);
    chk("div_dz", 32'(dz), 32'h0);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);

    issue(5'h0E, 32'h80000000, 32'hFFFFFFFF);
    run_md(0, 0, bc, done, dz, stray);
    chk("div_ovf_lo", lo, 32'h80000000);
    chk("div_ovf_hi", hi, 32'h0);

    issue(5'h0F, 32'd100, 32'd7);
    run_md(0, 0, bc, done, dz, stray);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);

    // divide by zero: one busy cycle
    issue(5'h0F, 32'h7, 32'h0);
    run_md(0, 0, bc, done, dz, stray);
    chk("divz_busy_cycles", 32'(bc), 32'd1);
    chk("divz_done", 32'(done), 32'h1);
    chk("divz_flag", 32'(dz), 32'h1);
    chk("divz_lo", lo, 32'hFFFFFFFF);
    chk("divz_hi", hi, 32'h7);

    issue(5'h0E, 32'hFFFFFFFB, 32'h0);
    run_md(0, 0, bc, done, dz, stray);
    chk("divz_signed_hi", hi, 32'hFFFFFFFB);
    chk("divz_signed_flag", 32'(dz), 32'h1);

    // flush at 10th busy cycle of a MULT
    issue(5'h12, 32'hA5, 32'h0);
    issue(5'h13, 32'h5A, 32'h0);
    issue(5'h0C, 32'h3, 32'h4);
    run_md(10, 1, bc, done, dz, stray);
    chk("flush_bc", 32'(bc), 32'd10);
    chk("flush_busy", 32'(busy), 32'h0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (md_done) seen = 1;
    end
    chk("flush_no_done", 32'(seen), 32'h0);
    chk("flush_hi", hi, 32'hA5);
    chk("flush_lo", lo, 32'h5A);

    // requests presented together with flush are dropped
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1; op = 5'h01; opr_a = 32'h1; opr_b = 32'h1;
    @(posedge clk); #1;
    chk("flush_drop_valid", 32'(out_valid), 32'h0);
    @(negedge clk);
    op = 5'h12; opr_a = 32'hDEAD;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_drop_mthi", hi, 32'hA5);

    // async reset in the middle of a DIV
    issue(5'h0E, 32'd100, 32'd7);
    repeat (5) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("areset_busy", 32'(busy), 32'h0);
    chk("areset_hi", hi, 32'h0);
    chk("areset_lo", lo, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    issue(5'h01, 32'h2, 32'h3);
    chk("post_reset_add", result, 32'h5);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
Parametrised, registered execute unit that supersedes the combinational EX-stage ALU. It adds signed/unsigned compare and correct arithmetic right shift, plus an iterative multiply/divide engine with HI/LO registers. A busy/stall handshake lets the pipeline hazard unit freeze IF/ID/EX while a mul/div is in flight. Operand forwarding and immediate selection happen upstream; this block consumes final operands.

Parameters:
XLEN, 32, datapath width (even, >= 8)
SHAMT_W, 5, shift-amount width; must equal log2(XLEN)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operation presented this cycle
op  input  5  operation code (see Behaviour)
opr_a  input  XLEN  operand A; shifts use opr_a[SHAMT_W-1:0] as shift amount
opr_b  input  XLEN  operand B; shifted value for shifts
flush  input  1  synchronous abort of in-flight/incoming operation
busy  output  1  mul/div in progress; upstream must hold in_valid low
out_valid  output  1  result valid, one-cycle pulse
result  output  XLEN  registered result
zero  output  1  result == 0, qualified by out_valid
hi  output  XLEN  HI register
lo  output  XLEN  LO register
md_done  output  1  one-cycle pulse: hi/lo hold new mul/div result
div_by_zero  output  1  pulses with md_done when divisor was 0
ovf  output  1  trapping-op overflow pulse (see Optional Feature)

Behaviour:
- Reset (rst_n low, async): FSM=IDLE; result, hi, lo, iteration counter = 0; busy, out_valid, zero, md_done, div_by_zero, ovf = 0.
- Op codes: 01 ADD, 02 SUB, 03 AND, 04 OR, 05 XOR, 06 NOR, 07 SLTU, 08 SLL, 09 SRL, 0A SRA, 0B SLT (signed), 0C MULT, 0D MULTU, 0E DIV, 0F DIVU, 10 MFHI, 11 MFLO, 12 MTHI (hi<=opr_a), 13 MTLO (lo<=opr_a).
- Single-cycle ops (01-0B, 10, 11): accepted at edge N -> out_valid=1, result/zero valid in cycle N+1. ADD/SUB wrap mod 2^XLEN. SRA sign-fills. Shift amount uses only the low SHAMT_W bits.
- MTHI/MTLO: hi/lo updated at the accepting edge; no out_valid.
- Undefined op codes (00, 14-1F without feature): out_valid pulses, result=0, zero=1.
- FSM states: IDLE, MUL, DIV, FIX.
- IDLE -> MUL/DIV on accepted 0C-0F. Operands are latched as magnitudes for signed ops; sign flags are latched.
- MUL/DIV run XLEN iterations: shift-add multiply; restoring divide.
- FIX: one cycle to apply signs, write hi/lo, then return to IDLE.
- Latency: accepted at edge N; busy=1 for cycles N+1..N+XLEN+1; md_done=1 in cycle N+XLEN+2.
- MULT/MULTU: {hi,lo} = full 2*XLEN product.
- DIV/DIVU: lo = quotient, hi = remainder. Quotient is truncated toward zero; remainder takes the dividend's sign.
- Divide overflow (signed MIN / -1): lo = MIN, hi = 0, produced by the normal algorithm.
- Divisor 0: FSM goes IDLE->FIX directly (busy 1 cycle). Result: lo = all ones, hi = opr_a, div_by_zero pulses with md_done.
- in_valid while busy: ignored, no state change. MFHI/MFLO issued while busy: ignored; upstream stall guarantees this does not occur.
- flush: if busy, FSM -> IDLE at that edge. hi/lo are unchanged and no md_done is produced. A request presented in the same cycle as flush is dropped, including its out_valid.
- Back-to-back single-cycle ops are accepted every cycle. MFHI in the cycle md_done is high returns the new hi.

Optional Feature:
Macro ALU_OVERFLOW_EN.
- Defined: op 14 ADDT and 15 SUBT perform signed add/subtract.
  - On signed overflow: ovf=1 in cycle N+1, out_valid=0, result holds its previous value.
  - Without overflow: behaves as ADD/SUB.
- Undefined: 14/15 are undefined op codes; ovf is tied 0.

Test Plan:
- ADD 0x7FFFFFFF+0x00000001 -> N+1 out_valid=1, result=0x80000000, zero=0; SUB 5-5 -> result=0, zero=1.
- SRA a=4, b=0x80000000 -> 0xF8000000; SRL same -> 0x08000000; SLT a=0xFFFFFFFF, b=1 -> 1; SLTU same -> 0.
- MULT 0xFFFFFFFF x 7 -> busy 33 cycles, md_done, hi=0xFFFFFFFF, lo=0xFFFFFFF9; then MFLO -> result=0xFFFFFFF9.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 7/0 -> busy 1 cycle, md_done and div_by_zero pulse, lo=0xFFFFFFFF, hi=7.
- MTHI 0xA5, then MULT with flush at 10th busy cycle -> busy low next cycle, no md_done, hi=0xA5. A later DIV interrupted by rst_n low -> busy=0, hi=lo=0 immediately.
